// File: rtl/sa_pkg.sv
// Shared constants and state encoding for the 3x3 systolic-array feeder.
package sa_pkg;
   localparam int NUM_LANES = 3;
   localparam int WIN_LEN   = 3;
   localparam int FEED_LEN  = 5;
   localparam int ELEM_W    = 8;
   localparam int ROW_W     = WIN_LEN * ELEM_W;
   localparam int WORD_W    = NUM_LANES * ROW_W;
   localparam int STEP_W    = 3;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_FEED  = 3'd2,
      S_DRAIN = 3'd3,
      S_HOLD  = 3'd4
   } sa_state_t;
endpackage

// File: rtl/sa_skew_lane.sv
// One skewed lane: lane LANE carries row element [LANE][step-LANE] while in range.
module sa_skew_lane
   import sa_pkg::*;
#(
   parameter int LANE = 0
) (
   input  logic              i_en,
   input  logic [STEP_W-1:0] i_step,
   input  logic [ROW_W-1:0]  i_row_d,
   input  logic [ROW_W-1:0]  i_row_w,
   output logic [ELEM_W-1:0] o_d,
   output logic [ELEM_W-1:0] o_w
);
   always_comb begin
      o_d = '0;
      o_w = '0;
      if (i_en) begin
         for (int j = 0; j < WIN_LEN; j++) begin
            if (int'(i_step) == LANE + j) begin
               o_d = i_row_d[j*ELEM_W +: ELEM_W];
               o_w = i_row_w[j*ELEM_W +: ELEM_W];
            end
         end
      end
   end
endmodule

// File: rtl/sa3x3_feeder.sv
// Latches a 3x3 data/weight window, clears the array, feeds it skewed over five
// steps, waits out the array latency and holds the captured result for handoff.
module sa3x3_feeder
   import sa_pkg::*;
#(
   parameter int SA_LATENCY = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   input  logic [WORD_W-1:0] in_weight,
   output logic              sa_clear,
   output logic [ELEM_W-1:0] sa_din0,
   output logic [ELEM_W-1:0] sa_din1,
   output logic [ELEM_W-1:0] sa_din2,
   output logic [ELEM_W-1:0] sa_win0,
   output logic [ELEM_W-1:0] sa_win1,
   output logic [ELEM_W-1:0] sa_win2,
   input  logic [ELEM_W-1:0] sa_out,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ELEM_W-1:0] res_data
);
   localparam logic [7:0]        LAST_DRAIN = 8'(SA_LATENCY - 1);
   localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(FEED_LEN - 1);

   sa_state_t                         r_state;
   logic [STEP_W-1:0]                 r_step;
   logic [7:0]                        r_drain;
   logic [WORD_W-1:0]                 r_data;
   logic [WORD_W-1:0]                 r_weight;
   logic                              r_clear;
   logic [NUM_LANES-1:0][ELEM_W-1:0]  r_din;
   logic [NUM_LANES-1:0][ELEM_W-1:0]  r_win;
   logic                              r_res_valid;
   logic [ELEM_W-1:0]                 r_res_data;

   logic                              w_accept;
   logic                              w_load;
   logic [STEP_W-1:0]                 w_next_step;
   logic [NUM_LANES-1:0][ELEM_W-1:0]  w_d;
   logic [NUM_LANES-1:0][ELEM_W-1:0]  w_w;

   // A completing handshake in HOLD doubles as the IDLE cycle, so back-to-back
   // windows need no bubble.
   assign in_ready = (r_state == S_IDLE) || ((r_state == S_HOLD) && res_ready);
   assign w_accept = in_valid && in_ready;

   // Lanes are registered, so select the step that will be on the wires next cycle.
   assign w_load      = (r_state == S_CLEAR) || ((r_state == S_FEED) && (r_step != LAST_STEP));
   assign w_next_step = (r_state == S_CLEAR) ? '0 : r_step + 1'b1;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      sa_skew_lane #(.LANE(g)) u_lane (
         .i_en    (w_load),
         .i_step  (w_next_step),
         .i_row_d (r_data[g*ROW_W +: ROW_W]),
         .i_row_w (r_weight[g*ROW_W +: ROW_W]),
         .o_d     (w_d[g]),
         .o_w     (w_w[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_step      <= '0;
         r_drain     <= '0;
         r_data      <= '0;
         r_weight    <= '0;
         r_clear     <= 1'b0;
         r_din       <= '0;
         r_win       <= '0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
      end else begin
         r_clear <= 1'b0;
         r_din   <= w_load ? w_d : '0;
         r_win   <= w_load ? w_w : '0;
         case (r_state)
            S_IDLE: begin
            end
            S_CLEAR: begin
               r_state <= S_FEED;
               r_step  <= '0;
            end
            S_FEED: begin
               if (r_step == LAST_STEP) begin
                  r_state <= S_DRAIN;
                  r_drain <= '0;
               end else begin
                  r_step <= r_step + 1'b1;
               end
            end
            S_DRAIN: begin
               if (r_drain == LAST_DRAIN) begin
                  r_res_data  <= sa_out;
                  r_res_valid <= 1'b1;
                  r_state     <= S_HOLD;
               end else begin
                  r_drain <= r_drain + 1'b1;
               end
            end
            S_HOLD: begin
               if (res_ready) begin
                  r_res_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
         if (w_accept) begin
            r_data   <= in_data;
            r_weight <= in_weight;
            r_clear  <= 1'b1;
            r_state  <= S_CLEAR;
         end
      end
   end

   assign sa_clear  = r_clear;
   assign sa_din0   = r_din[0];
   assign sa_din1   = r_din[1];
   assign sa_din2   = r_din[2];
   assign sa_win0   = r_win[0];
   assign sa_win1   = r_win[1];
   assign sa_win2   = r_win[2];
   assign res_valid = r_res_valid;
   assign res_data  = r_res_data;
endmodule
